bus_master: RTL and testbench
=============================

BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles ADDR/DATA are stable before the strobe; legal 1..255, 0 treated as 1.
REQ-002 Parameter STROBE_CYC, default 2: cycles WR or RD is held high; legal 1..255, 0 treated as 1.
REQ-003 Parameter HOLD_CYC, default 1: cycles ADDR (and write DATA) are held after the strobe falls; legal 1..255, 0 treated as 1.
REQ-004 Parameter FIFO_DEPTH, default 4: command FIFO entries; power of two, 2..16.
REQ-005 SYSCLK  in  1  single clock; all logic on its rising edge.
REQ-006 SYSRSTn  in  1  reset, asynchronous assert, active-low.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  FIFO can accept; equals FIFO not full.
REQ-009 cmd_wr  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  16  target bus address.
REQ-011 cmd_wdata  in  32  write data; ignored for reads.
REQ-012 rsp_valid  out  1  one-cycle pulse: read data available.
REQ-013 rsp_rdata  out  32  captured read data; holds until the next read capture.
REQ-014 busy  out  1  FSM not IDLE or FIFO non-empty.
REQ-015 WR  out  1  bus write strobe, registered.
REQ-016 RD  out  1  bus read strobe, registered.
REQ-017 ADDR  out  16  bus address, registered.
REQ-018 DATA  inout  32  bidirectional data bus.

Function
REQ-019 A command is pushed on a rising edge where cmd_valid=1 and cmd_ready=1; {cmd_wr, cmd_addr, cmd_wdata} are stored in order.
REQ-020 cmd_ready is 0 when the FIFO is full, even in a cycle where a pop also occurs; a simultaneous push and pop in a non-full FIFO leaves the count unchanged.
REQ-021 The FSM has states IDLE, SETUP, STROBE, HOLD.
REQ-022 IDLE -> SETUP on an edge where the FIFO is non-empty; the head entry is popped and latched, and ADDR takes its address.
REQ-023 SETUP lasts SETUP_CYC cycles with WR=RD=0, then -> STROBE.
REQ-024 STROBE lasts STROBE_CYC cycles with WR=1 for writes or RD=1 for reads, then -> HOLD.
REQ-025 HOLD lasts HOLD_CYC cycles with WR=RD=0, then -> IDLE.
REQ-026 The FSM spends at least one cycle in IDLE between consecutive transactions.
REQ-027 ADDR is stable from SETUP entry through the end of HOLD, and keeps its last value while IDLE.
REQ-028 DATA is driven with the latched wdata only during SETUP, STROBE and HOLD of a write; at all other times it is high-impedance.
REQ-029 DATA is never driven while RD=1, and WR and RD are never 1 simultaneously.
REQ-030 For a read, DATA is sampled into rsp_rdata on the edge that ends the last STROBE cycle.
REQ-031 rsp_valid is 1 for exactly one cycle, the cycle after the last HOLD cycle of a read; writes produce no response.
REQ-032 Phase counters are 8 bits and count down from the parameter value minus 1 to 0.
REQ-033 Default-parameter write timing: push at edge E0; SETUP after E1; WR=1 after E2 through E4; HOLD after E4; IDLE after E5.

Reset
REQ-034 While SYSRSTn=0: WR=0, RD=0, ADDR=0, DATA=Z, rsp_valid=0, rsp_rdata=0, cmd_ready=0, busy=0, FIFO emptied, FSM in IDLE, counters at 0.
REQ-035 A reset asserted during a transaction aborts it immediately and asynchronously drops the strobe; the transaction is not retried and produces no response.
REQ-036 cmd_ready returns to 1 on the first SYSCLK edge after SYSRSTn deasserts.

Verification
REQ-037 Write addr 0x0708, data 0x00000003, default parameters -> ADDR=0x0708 after E1; WR high for exactly 2 cycles after E2; DATA=0x00000003 from E1 to E5; no rsp_valid.
REQ-038 Read addr 0x070C, bench drives 0x00120140 while RD=1 -> RD high for 2 cycles; rsp_rdata=0x00120140; rsp_valid pulses once, the cycle after HOLD.
REQ-039 Push 4 writes back-to-back while the FSM is stalled in the first transaction -> cmd_ready=0 after the 4th push; a 5th cmd_valid is not accepted; all 4 writes issue in push order.
REQ-040 Write then read with no gap -> IDLE cycle between them; DATA is Z before RD rises; no cycle with DATA driven while RD=1.
REQ-041 Assert SYSRSTn=0 mid-STROBE of a read -> RD=0 asynchronously; DATA=Z; rsp_valid never pulses; busy=0.
REQ-042 SETUP_CYC=0, STROBE_CYC=3, HOLD_CYC=2 -> 1 setup cycle, 3 strobe cycles, 2 hold cycles.

Source files
------------

// File: rtl/bus_master_if.sv
// Command/response interface of bus_master.
// Handshake: a command transfers on a rising SYSCLK edge where cmd_valid=1
// and cmd_ready=1. While cmd_valid=1 and cmd_ready=0 the issuer holds
// cmd_wr/cmd_addr/cmd_wdata stable. rsp_valid is a one-cycle pulse with no
// back-pressure, and rsp_rdata holds its value until the next read capture.
interface bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;

  // bus_master side
  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );

  // command issuer side
  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/bus_master.sv
// Simple parallel-bus master: commands are queued in a small FIFO and each
// one is played out as SETUP -> STROBE -> HOLD with registered WR/RD/ADDR and
// a tri-state DATA bus. Reads capture DATA at the end of the strobe and
// report it with a one-cycle rsp_valid pulse after the hold phase.
module bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         SYSCLK,
  input  logic         SYSRSTn,
  bus_master_if.master cmd,
  output logic         WR,
  output logic         RD,
  output logic [15:0]  ADDR,
  inout  wire  [31:0]  DATA,
  output logic [1:0]   dbg_state,
  output logic         data_oe
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 49;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  // A phase of N cycles loads N-1 and leaves when the counter reaches 0;
  // a parameter of 0 behaves like 1.
  localparam logic [7:0] SETUP_LD  = (SETUP_CYC  <= 1) ? 8'd0 : 8'(SETUP_CYC  - 1);
  localparam logic [7:0] STROBE_LD = (STROBE_CYC <= 1) ? 8'd0 : 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = (HOLD_CYC   <= 1) ? 8'd0 : 8'(HOLD_CYC   - 1);

  // IDLE encodes as 0 so an observer of dbg_state can spot idle cycles.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [7:0]      cnt, cnt_next;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            ready_en;
  logic            push, pop, full, empty;
  logic [EW-1:0]   head;
  logic            lat_wr;
  logic [31:0]     lat_wdata;
  logic            wr_sel;

  assign full          = (count == DEPTH_C);
  assign empty         = (count == '0);
  // ready_en keeps cmd_ready low during reset and until the first edge after it.
  assign cmd.cmd_ready = ready_en & ~full;
  assign push          = cmd.cmd_valid & cmd.cmd_ready;
  assign head          = mem[rd_ptr];
  assign cmd.busy      = (state != S_IDLE) | ~empty;
  assign dbg_state     = state;
  assign DATA          = data_oe ? lat_wdata : {32{1'bz}};

  // The transaction kind is taken from the FIFO head on the pop edge,
  // otherwise from the latched command.
  assign wr_sel = pop ? head[48] : lat_wr;

  // FIFO storage: entries are {wr, addr, wdata}; validity is tracked by count.
  always_ff @(posedge SYSCLK) begin
    if (push) mem[wr_ptr] <= {cmd.cmd_wr, cmd.cmd_addr, cmd.cmd_wdata};
  end

  // FIFO pointers, occupancy and the post-reset ready enable.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state and phase counter registers.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: each phase counts down from its load value to 0.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_next = S_SETUP;
          cnt_next   = SETUP_LD;
          pop        = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt == 8'd0) begin
          state_next = S_STROBE;
          cnt_next   = STROBE_LD;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      S_STROBE: begin
        if (cnt == 8'd0) begin
          state_next = S_HOLD;
          cnt_next   = HOLD_LD;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt == 8'd0) begin
          state_next = S_IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Registered bus outputs, command latch, read capture and response pulse.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      WR            <= 1'b0;
      RD            <= 1'b0;
      ADDR          <= 16'h0000;
      data_oe       <= 1'b0;
      lat_wr        <= 1'b0;
      lat_wdata     <= 32'h0;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_rdata <= 32'h0;
    end else begin
      if (pop) begin
        lat_wr    <= head[48];
        ADDR      <= head[47:32];
        lat_wdata <= head[31:0];
      end
      WR            <= (state_next == S_STROBE) &  wr_sel;
      RD            <= (state_next == S_STROBE) & ~wr_sel;
      data_oe       <= (state_next != S_IDLE)   &  wr_sel;
      cmd.rsp_valid <= (state == S_HOLD) & (state_next == S_IDLE) & ~lat_wr;
      if ((state == S_STROBE) && (state_next == S_HOLD) && !lat_wr)
        cmd.rsp_rdata <= DATA;
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: a default-parameter instance driven with directed
// and random commands against a queue-based model, plus a second instance
// with SETUP_CYC=0, STROBE_CYC=3, HOLD_CYC=2 for phase-length checks.
module tb_bus_master;
  localparam int S1 = 1, T1 = 2, H1 = 1, DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_master_if c1 ();
  bus_master_if c2 ();

  logic        wr1, rd1, oe1, wr2, rd2, oe2;
  logic [15:0] addr1, addr2;
  logic [1:0]  st1, st2;
  wire  [31:0] data1, data2;
  logic [31:0] slave_val1 = 32'h0;

  // Bus slave models: drive DATA only while the strobe asks for a read.
  assign data1 = rd1 ? slave_val1 : {32{1'bz}};
  assign data2 = rd2 ? 32'hCAFE_0042 : {32{1'bz}};

  bus_master u_dut (
    .SYSCLK(clk), .SYSRSTn(rst_n), .cmd(c1),
    .WR(wr1), .RD(rd1), .ADDR(addr1), .DATA(data1),
    .dbg_state(st1), .data_oe(oe1)
  );

  bus_master #(.SETUP_CYC(0), .STROBE_CYC(3), .HOLD_CYC(2), .FIFO_DEPTH(4)) u_dut2 (
    .SYSCLK(clk), .SYSRSTn(rst_n), .cmd(c2),
    .WR(wr2), .RD(rd2), .ADDR(addr2), .DATA(data2),
    .dbg_state(st2), .data_oe(oe2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [48:0] txn_q[$];    // expected bus transactions {wr, addr, wdata}, in order
  logic [31:0] exp_q[$];    // expected read responses, in order
  logic [31:0] slave_q[$];  // data the bus slave returns for each read

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=no_event t=%0t", name, $time);
  endtask

  // Bus slave for instance 1: pick the next read value when RD rises.
  logic rd1_seen = 1'b0;
  always @(negedge clk) begin
    if (rd1 && !rd1_seen && slave_q.size() > 0) slave_val1 = slave_q.pop_front();
    rd1_seen = rd1;
  end

  // ---------------- monitor for instance 1 ----------------
  logic        strobe_on = 1'b0, prev_oe = 1'b0, prev_rsp = 1'b0;
  logic        seen_idle = 1'b1, txn_act = 1'b0;
  int          slen = 0, oe_run = 0, since_fall = -1;
  logic [48:0] cur = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      strobe_on = 1'b0; prev_oe = 1'b0; prev_rsp = 1'b0;
      seen_idle = 1'b1; txn_act = 1'b0;
      slen = 0; oe_run = 0; since_fall = -1;
    end else begin
      if (wr1 | rd1) begin
        chk("wr_rd_exclusive", wr1 & rd1, 0);
        chk("data_driven_during_rd", oe1 & rd1, 0);
      end
      if (st1 == 2'd0) seen_idle = 1'b1;
      if ((wr1 | rd1) && !strobe_on) begin
        strobe_on  = 1'b1;
        slen       = 0;
        since_fall = -1;
        if (txn_q.size() == 0) begin
          flag("unexpected_strobe");
          txn_act = 1'b0;
        end else begin
          cur     = txn_q.pop_front();
          txn_act = 1'b1;
          chk("strobe_is_write", wr1, cur[48]);
          chk("idle_between_txn", seen_idle, 1);
          if (cur[48]) chk("setup_cycles", oe_run, S1);
        end
        seen_idle = 1'b0;
      end
      if (wr1 | rd1) slen++;
      if (!(wr1 | rd1) && strobe_on) begin
        strobe_on = 1'b0;
        chk("strobe_cycles", slen, T1);
        since_fall = 0;
      end else if (since_fall >= 0) begin
        since_fall++;
      end
      if (txn_act) begin
        chk("addr_stable", addr1, cur[47:32]);
        if (cur[48] && oe1) chk("write_data", data1, cur[31:0]);
        if (st1 == 2'd0) txn_act = 1'b0;
      end
      if (oe1) oe_run++;
      else begin
        if (prev_oe) chk("data_drive_cycles", oe_run, S1 + T1 + H1);
        oe_run = 0;
      end
      prev_oe = oe1;
      if (c1.rsp_valid) begin
        chk("rsp_single_cycle", prev_rsp, 0);
        chk("rsp_after_hold", since_fall, H1);
        if (exp_q.size() == 0) flag("unexpected_rsp");
        else chk("rsp_rdata", c1.rsp_rdata, exp_q.pop_front());
      end
      prev_rsp = c1.rsp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic wr, input logic [15:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata);
    bit done = 1'b0;
    c1.cmd_valid = 1'b1; c1.cmd_wr = wr; c1.cmd_addr = addr; c1.cmd_wdata = wdata;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (c1.cmd_ready) begin
        @(posedge clk); #1;
        txn_q.push_back({wr, addr, wdata});
        if (!wr) begin
          slave_q.push_back(rdata);
          exp_q.push_back(rdata);
        end
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    c1.cmd_valid = 1'b0;
    if (!done) flag("push_timeout");
  endtask

  task automatic push2(input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
    bit done = 1'b0;
    c2.cmd_valid = 1'b1; c2.cmd_wr = wr; c2.cmd_addr = addr; c2.cmd_wdata = wdata;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (c2.cmd_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    c2.cmd_valid = 1'b0;
    if (!done) flag("push2_timeout");
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk); #1;
      if (!c1.busy && txn_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    chk("drain", done, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  int          acc, p_setup, p_strb, p_hold;
  bit          seen, fin, got;
  logic [15:0] fa;
  logic [31:0] fd;

  initial begin
    c1.cmd_valid = 1'b0; c1.cmd_wr = 1'b0; c1.cmd_addr = '0; c1.cmd_wdata = '0;
    c2.cmd_valid = 1'b0; c2.cmd_wr = 1'b0; c2.cmd_addr = '0; c2.cmd_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // reset state
    chk("rst_wr", wr1, 0);
    chk("rst_rd", rd1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_data_oe", oe1, 0);
    chk("rst_rsp_valid", c1.rsp_valid, 0);
    chk("rst_rsp_rdata", c1.rsp_rdata, 0);
    chk("rst_cmd_ready", c1.cmd_ready, 0);
    chk("rst_busy", c1.busy, 0);
    chk("rst_state_idle", st1, 0);
    rst_n = 1'b1;
    #1 chk("ready_before_first_edge", c1.cmd_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_first_edge", c1.cmd_ready, 1);

    // directed write, then directed read
    push(1'b1, 16'h0708, 32'h0000_0003, 32'h0);
    chk("busy_after_push", c1.busy, 1);
    wait_drain();
    push(1'b0, 16'h070C, 32'h0, 32'h0012_0140);
    wait_drain();
    chk("rsp_rdata_holds", c1.rsp_rdata, 32'h0012_0140);

    // write immediately followed by read
    push(1'b1, 16'h1000, 32'hDEAD_BEEF, 32'h0);
    push(1'b0, 16'h1004, 32'h0, 32'h5555_AAAA);
    wait_drain();

    // fill the FIFO while the first transaction is in progress
    acc = 0;
    fa = 16'($urandom); fd = $urandom;
    c1.cmd_valid = 1'b1; c1.cmd_wr = 1'b1; c1.cmd_addr = fa; c1.cmd_wdata = fd;
    for (int i = 0; i < 20 && acc < DEPTH + 1; i++) begin
      @(negedge clk);
      if (c1.cmd_ready) begin
        @(posedge clk); #1;
        txn_q.push_back({1'b1, fa, fd});
        acc++;
        fa = 16'($urandom); fd = $urandom;
        c1.cmd_addr = fa; c1.cmd_wdata = fd;
      end else begin
        @(posedge clk); #1;
      end
    end
    // one entry sits in the FSM, DEPTH entries fill the FIFO
    chk("full_accept_count", acc, DEPTH + 1);
    // the second of these edges also pops; the held command must still be refused
    repeat (2) begin
      @(negedge clk);
      chk("full_ready_low", c1.cmd_ready, 0);
      @(posedge clk); #1;
    end
    c1.cmd_valid = 1'b0;
    wait_drain();

    // random traffic
    for (int n = 0; n < 40; n++) begin
      push(1'($urandom_range(0, 1)), 16'($urandom), $urandom, $urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain();

    // second instance: SETUP_CYC=0 -> 1, STROBE_CYC=3, HOLD_CYC=2
    push2(1'b1, 16'h1234, 32'hA5A5_0001);
    p_setup = 0; p_strb = 0; p_hold = 0; seen = 1'b0; fin = 1'b0;
    for (int i = 0; i < 80 && !fin; i++) begin
      @(negedge clk);
      if (oe2 && !wr2 && !seen) p_setup++;
      if (wr2) begin
        p_strb++;
        seen = 1'b1;
        chk("p2_write_data", data2, 32'hA5A5_0001);
        chk("p2_write_addr", addr2, 16'h1234);
      end
      if (oe2 && !wr2 && seen) p_hold++;
      if (seen && !oe2) fin = 1'b1;
    end
    chk("p2_write_done", fin, 1);
    chk("p2_write_setup", p_setup, 1);
    chk("p2_write_strobe", p_strb, 3);
    chk("p2_write_hold", p_hold, 2);
    repeat (3) @(posedge clk);
    #1;
    push2(1'b0, 16'h4321, 32'h0);
    p_setup = 0; p_strb = 0; p_hold = 0; seen = 1'b0; fin = 1'b0;
    for (int i = 0; i < 80 && !fin; i++) begin
      @(negedge clk);
      if (st2 != 2'd0 && !rd2 && !seen) p_setup++;
      if (rd2) begin
        p_strb++;
        seen = 1'b1;
        chk("p2_no_drive_during_rd", oe2, 0);
      end
      if (seen && !rd2 && !c2.rsp_valid) p_hold++;
      if (c2.rsp_valid) begin
        fin = 1'b1;
        chk("p2_rsp_rdata", c2.rsp_rdata, 32'hCAFE_0042);
      end
    end
    chk("p2_read_done", fin, 1);
    chk("p2_read_setup", p_setup, 1);
    chk("p2_read_strobe", p_strb, 3);
    chk("p2_read_hold", p_hold, 2);
    @(posedge clk); #1;

    // reset in the middle of a read strobe
    push(1'b0, 16'h0BAD, 32'h0, $urandom);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rd1) got = 1'b1;
    end
    chk("abort_rd_reached", got, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rd_low", rd1, 0);
    chk("abort_wr_low", wr1, 0);
    chk("abort_data_released", oe1, 0);
    chk("abort_busy_low", c1.busy, 0);
    chk("abort_ready_low", c1.cmd_ready, 0);
    txn_q.delete();
    exp_q.delete();
    slave_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp_in_reset", c1.rsp_valid, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_after_release", c1.cmd_ready, 1);
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_rsp_after", c1.rsp_valid, 0);
    end
    chk("abort_busy_after", c1.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // run-time bound
  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
